mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, 2, number of ACCESS cycles per memory transaction, legal range 1..15.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: DW, 32, data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1  instruction-port read request.
REQ-007 i_addr  in  AW  instruction-port byte address.
REQ-008 i_ack  out  1  one-cycle pulse: instruction transaction complete.
REQ-009 i_rdata  out  DW  instruction read data, valid when i_ack=1, held until the next i_ack.
REQ-010 d_req  in  1  data-port request.
REQ-011 d_we  in  1  data-port write enable: 1 = write, 0 = read.
REQ-012 d_addr  in  AW  data-port byte address.
REQ-013 d_wdata  in  DW  data-port write data.
REQ-014 d_ack  out  1  one-cycle pulse: data transaction complete.
REQ-015 d_rdata  out  DW  data read data, valid when d_ack=1 after a read, held until the next d_ack.
REQ-016 address  out  AW  to datamem address.
REQ-017 Writedata  out  DW  to datamem write data.
REQ-018 memread  out  1  to datamem read strobe.
REQ-019 memwrite  out  1  to datamem write strobe.
REQ-020 readdata  in  DW  from datamem; combinational read.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when any req=1.
- ACCESS -> DONE when the latency counter reaches 0.
- DONE -> IDLE unconditionally.
REQ-023 Arbitration in IDLE:
- Single requester: that requester is granted.
- Both requesting: the port not granted last time wins (round-robin).
- last_grant resets to INSTR, so the first tie goes to the data port.
REQ-024 On grant, addr/wdata/we of the winner are latched; address and Writedata drive the latched values, stable through ACCESS.
REQ-025 ACCESS lasts exactly LATENCY cycles; the counter loads LATENCY-1 on grant and decrements each ACCESS cycle.
REQ-026 memread=1 for all ACCESS cycles of a read; memwrite=1 only in the final ACCESS cycle of a write, giving one write edge.
REQ-027 readdata is captured on the final ACCESS edge into the granted port's rdata register; the other port's rdata is unchanged.
REQ-028 Ack behaviour:
- The granted ack pulses for exactly the one DONE cycle.
- Latency: req sampled at edge T gives ack high in cycle T+LATENCY+1.
REQ-029 memread=memwrite=0 in IDLE and DONE; address and Writedata hold their last values.
REQ-030 Requesters hold req and payload until ack; req sampled during DONE is ignored; a request re-asserted in IDLE starts a new transaction.
REQ-031 A req deasserted mid-transaction has no effect; the transaction completes and ack still pulses.
REQ-032 The instruction port never writes; i_req is never granted as a write.
REQ-033 Addresses pass unmodified; no alignment checking.

Reset
REQ-034 Values after the rst edge:
- state=IDLE, counter=0, last_grant=INSTR.
- memread=0, memwrite=0, i_ack=0, d_ack=0, busy=0.
- address=0, Writedata=0, i_rdata=0, d_rdata=0.
REQ-035 rst asserted mid-ACCESS aborts the transaction: no ack, and memwrite is low in the cycle after the reset edge.

Structure
REQ-036 Package mem_arb_pkg holds the state enum {IDLE, ACCESS, DONE}, the grant enum {INSTR, DATA} and the default LATENCY constant.
REQ-037 Single module; no sub-module required.

Verification
REQ-038 Data write then read, LATENCY=2:
- d_req, d_we=1, addr 0x10, data 0xDEADBEEF -> memwrite high one cycle, d_ack at T+3.
- Read of 0x10 -> d_rdata=0xDEADBEEF.
REQ-039 Simultaneous i_req (0x0) and d_req (0x4) after reset:
- Data served first, then instruction.
- i_ack exactly LATENCY+2 cycles after d_ack.
REQ-040 Continuous requests on both ports for 8 transactions -> grants alternate D,I,D,I...; no port starved.
REQ-041 LATENCY=1, single i_req at 0x8 -> memread high one cycle, i_ack at T+2 with datamem contents.
REQ-042 rst asserted during ACCESS of a write:
- No d_ack, memwrite=0 after the edge, memory word unchanged.
- All outputs at their reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, grant owner, default latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {INSTR, DATA} grant_t;

    localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory between an instruction read port
// and a data read/write port; each transaction takes LATENCY access cycles plus one ack cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] address,
    output logic [DW-1:0] Writedata,
    output logic          memread,
    output logic          memwrite,
    input  logic [DW-1:0] readdata,
    output logic          busy
);

    state_t     state, nstate;
    grant_t     grant, last_grant, win;
    logic [3:0] cnt;
    logic       we_q;

    // On a tie the port that lost last time wins.
    always_comb begin
        win = INSTR;
        if (i_req && d_req)
            win = (last_grant == INSTR) ? DATA : INSTR;
        else if (d_req)
            win = DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (i_req || d_req) nstate = ACCESS;
            ACCESS:  if (cnt == 4'd0)    nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Write strobe only in the last access cycle so memory sees a single write edge.
    always_comb begin
        busy     = (state != IDLE);
        memread  = (state == ACCESS) && !we_q;
        memwrite = (state == ACCESS) && we_q && (cnt == 4'd0);
        i_ack    = (state == DONE) && (grant == INSTR);
        d_ack    = (state == DONE) && (grant == DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            grant      <= INSTR;
            last_grant <= INSTR;
            we_q       <= 1'b0;
            address    <= '0;
            Writedata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    grant      <= win;
                    last_grant <= win;
                    cnt        <= 4'(LATENCY - 1);
                    if (win == DATA) begin
                        address   <= d_addr;
                        Writedata <= d_wdata;
                        we_q      <= d_we;
                    end else begin
                        address   <= i_addr;
                        we_q      <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else if (!we_q) begin
                        if (grant == DATA) d_rdata <= readdata;
                        else               i_rdata <= readdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LATENCY=2 and LATENCY=1 instances, each with its own word memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, mem_init;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        i_ack2, d_ack2, mr2, mw2, busy2;
    logic [31:0] i_rdata2, d_rdata2, address2, wd2, rd2;
    logic        i_ack1, d_ack1, mr1, mw1, busy1;
    logic [31:0] i_rdata1, d_rdata1, address1, wd1, rd1;

    logic [31:0] mem2 [64];
    logic [31:0] mem1 [64];
    logic [31:0] mref [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) u2 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack2), .i_rdata(i_rdata2),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack2), .d_rdata(d_rdata2),
        .address(address2), .Writedata(wd2), .memread(mr2), .memwrite(mw2),
        .readdata(rd2), .busy(busy2)
    );

    mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .address(address1), .Writedata(wd1), .memread(mr1), .memwrite(mw1),
        .readdata(rd1), .busy(busy1)
    );

    assign rd2 = mem2[address2[7:2]];
    assign rd1 = mem1[address1[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) begin
                mem2[k] <= 32'hA500_0000 | 32'(k);
                mem1[k] <= 32'hA500_0000 | 32'(k);
            end
        end else begin
            if (mw2) mem2[address2[7:2]] <= wd2;
            if (mw1) mem1[address1[7:2]] <= wd1;
        end
    end

    typedef struct {
        logic        ir, dr, we;
        logic [31:0] ia, da, wd;
        logic        exp_d;
        logic [31:0] exp_rd;
        int          exp_mw, exp_mr;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Counts edges (including the request-sampling edge) until an ack is seen.
    task automatic wait_ack(input bit use1, output int edges, output bit is_d,
                            output int nmr, output int nmw);
        bit done = 0;
        edges = 0; is_d = 0; nmr = 0; nmw = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            edges++;
            if (use1) begin
                nmr += int'(mr1); nmw += int'(mw1);
                if (i_ack1 || d_ack1) begin done = 1; is_d = d_ack1; end
            end else begin
                nmr += int'(mr2); nmw += int'(mw2);
                if (i_ack2 || d_ack2) begin done = 1; is_d = d_ack2; end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout got no ack want ack within 40 cycles");
            edges = -1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl2"}, {59'd0, mr2, mw2, i_ack2, d_ack2, busy2}, 64'd0);
        chk({tag, "_dat2"}, {address2, wd2}, 64'd0);
        chk({tag, "_rd2"}, {i_rdata2, d_rdata2}, 64'd0);
        chk({tag, "_ctl1"}, {59'd0, mr1, mw1, i_ack1, d_ack1, busy1}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1; i_req = 0; d_req = 0; d_we = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 0;
    endtask

    vec_t tbl[8];
    int   edges, nmr, nmw, cnt_ack;
    bit   is_d, exp_d, last_d, pi, pd, dwe_r;
    logic [31:0] ia_r, da_r, dwd_r;

    initial begin
        for (int k = 0; k < 64; k++) mref[k] = 32'hA500_0000 | 32'(k);
        tbl[0] = '{0, 1, 1, 32'h0,  32'h10, 32'hDEADBEEF, 1, 32'h0,        1, 0};
        tbl[1] = '{0, 1, 0, 32'h0,  32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 2};
        tbl[2] = '{1, 0, 0, 32'h10, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0, 2};
        tbl[3] = '{1, 1, 0, 32'h0,  32'h4,  32'h0,        1, 32'hA5000001, 0, 2};
        tbl[4] = '{1, 1, 0, 32'h8,  32'hC,  32'h0,        0, 32'hA5000002, 0, 2};
        tbl[5] = '{1, 1, 1, 32'h0,  32'h20, 32'h12345678, 1, 32'h0,        1, 0};
        tbl[6] = '{1, 0, 0, 32'h20, 32'h0,  32'h0,        0, 32'h12345678, 0, 2};
        tbl[7] = '{0, 1, 0, 32'h0,  32'h3C, 32'h0,        1, 32'hA500000F, 0, 2};

        i_addr = 0; d_addr = 0; d_wdata = 0;
        mem_init = 1;
        do_reset();
        mem_init = 0;

        // LATENCY=1 single instruction fetch
        i_req = 1; i_addr = 32'h8;
        wait_ack(1, edges, is_d, nmr, nmw);
        chk("l1_edges", 64'(edges), 64'd2);
        chk("l1_port", {63'd0, is_d}, 64'd0);
        chk("l1_memread", 64'(nmr), 64'd1);
        chk("l1_rdata", {32'd0, i_rdata1}, {32'd0, 32'hA5000002});
        i_req = 0;
        @(posedge clk); #1;

        // Directed table on the LATENCY=2 instance
        do_reset();
        foreach (tbl[n]) begin
            i_req = tbl[n].ir; d_req = tbl[n].dr; d_we = tbl[n].we;
            i_addr = tbl[n].ia; d_addr = tbl[n].da; d_wdata = tbl[n].wd;
            wait_ack(0, edges, is_d, nmr, nmw);
            chk($sformatf("t%0d_port", n), {63'd0, is_d}, {63'd0, tbl[n].exp_d});
            chk($sformatf("t%0d_edges", n), 64'(edges), 64'd3);
            chk($sformatf("t%0d_memread", n), 64'(nmr), 64'(tbl[n].exp_mr));
            chk($sformatf("t%0d_memwrite", n), 64'(nmw), 64'(tbl[n].exp_mw));
            chk($sformatf("t%0d_addr", n), {32'd0, address2},
                {32'd0, tbl[n].exp_d ? tbl[n].da : tbl[n].ia});
            if (tbl[n].exp_d && tbl[n].we)
                mref[tbl[n].da[7:2]] = tbl[n].wd;
            else
                chk($sformatf("t%0d_rdata", n), {32'd0, tbl[n].exp_d ? d_rdata2 : i_rdata2},
                    {32'd0, tbl[n].exp_rd});
            i_req = 0; d_req = 0;
            @(posedge clk); #1;
            chk($sformatf("t%0d_ack_pulse", n), {63'd0, i_ack2 | d_ack2}, 64'd0);
        end

        // Tie after reset: data first, instruction LATENCY+2 cycles later
        do_reset();
        i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h4;
        wait_ack(0, edges, is_d, nmr, nmw);
        chk("tie_first_port", {63'd0, is_d}, 64'd1);
        chk("tie_first_rdata", {32'd0, d_rdata2}, {32'd0, mref[1]});
        d_req = 0;
        wait_ack(0, edges, is_d, nmr, nmw);
        chk("tie_second_port", {63'd0, is_d}, 64'd0);
        chk("tie_gap", 64'(edges), 64'd4);
        chk("tie_second_rdata", {32'd0, i_rdata2}, {32'd0, mref[0]});
        i_req = 0;
        @(posedge clk); #1;

        // Both ports continuously requesting: strict alternation D,I,D,I...
        do_reset();
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'hC;
        for (int n = 0; n < 8; n++) begin
            wait_ack(0, edges, is_d, nmr, nmw);
            chk($sformatf("rr%0d_port", n), {63'd0, is_d}, 64'((n % 2) == 0));
            chk($sformatf("rr%0d_edges", n), 64'(edges), (n == 0) ? 64'd3 : 64'd4);
        end
        i_req = 0; d_req = 0;
        @(posedge clk); #1;

        // Randomized requests against a round-robin reference model
        do_reset();
        last_d = 0; pi = 0; pd = 0; dwe_r = 0;
        ia_r = 0; da_r = 0; dwd_r = 0;
        for (int r = 0; r < 30; r++) begin
            if (!pi && ($urandom % 2) == 1) begin
                pi = 1; ia_r = {26'd0, 4'($urandom % 16), 2'b00};
            end
            if (!pd && (($urandom % 2) == 1 || !pi)) begin
                pd = 1; dwe_r = 1'($urandom % 2);
                da_r = {26'd0, 4'($urandom % 16), 2'b00}; dwd_r = $urandom;
            end
            i_req = pi; i_addr = ia_r; d_req = pd; d_we = dwe_r; d_addr = da_r; d_wdata = dwd_r;
            exp_d = pd && (!pi || !last_d);
            wait_ack(0, edges, is_d, nmr, nmw);
            chk($sformatf("r%0d_port", r), {63'd0, is_d}, {63'd0, exp_d});
            chk($sformatf("r%0d_edges", r), 64'(edges), 64'd3);
            if (exp_d && dwe_r) begin
                chk($sformatf("r%0d_memwrite", r), 64'(nmw), 64'd1);
                mref[da_r[7:2]] = dwd_r;
            end else if (exp_d)
                chk($sformatf("r%0d_drdata", r), {32'd0, d_rdata2}, {32'd0, mref[da_r[7:2]]});
            else
                chk($sformatf("r%0d_irdata", r), {32'd0, i_rdata2}, {32'd0, mref[ia_r[7:2]]});
            last_d = exp_d;
            if (exp_d) pd = 0; else pi = 0;
            i_req = pi; d_req = pd;
            @(posedge clk); #1;
        end
        i_req = 0; d_req = 0;
        @(posedge clk); #1;

        // Reset during the ACCESS phase of a write aborts it
        i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("abort_busy", {63'd0, busy2}, 64'd1);
        rst = 1; d_req = 0;
        @(posedge clk); #1;
        chk("abort_memwrite", {63'd0, mw2}, 64'd0);
        chk_reset_vals("abort");
        rst = 0;
        cnt_ack = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (d_ack2 || mw2) cnt_ack++;
        end
        chk("abort_no_ack", 64'(cnt_ack), 64'd0);
        chk("abort_mem", {32'd0, mem2[12]}, {32'd0, mref[12]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
